// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - PLL lock supervisor state encoding and counter sizing helper
package pll_sup_pkg;

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } pll_sup_state_t;

    // One shared counter covers every timed phase, so size it for the longest one.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer, async active-low reset to 0
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset/lock supervisor gating the core reset
// Optional retry limit with terminal fault state: PLL_RETRY_LIMIT_EN.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 500000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 7,
    parameter int RETRY_W       = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pll_locked,
    output logic               pll_rst,
    output logic               core_reset_n,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_count
);

    localparam int CNT_W = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    // Configurations whose retry limit cannot be represented in retry_count elaborate this block.
    if (MAX_RETRIES > (2 ** RETRY_W) - 1) begin : g_max_retries_exceeds_retry_w
    end

    pll_sup_state_t     r_state;
    pll_sup_state_t     w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [RETRY_W-1:0] r_retry;
    logic [RETRY_W-1:0] w_retry_nxt;
    logic               r_pll_rst;
    logic               r_core_reset_n;
    logic               w_pll_rst_nxt;
    logic               w_core_reset_n_nxt;
    logic               w_locked_s;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .i_d   (pll_locked),
        .o_q   (w_locked_s)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_retry_nxt = r_retry;
        case (r_state)
            S_PLL_RST: begin
                if (r_cnt == RST_LAST) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end
            end
            S_WAIT_LOCK: begin
                // Lock is tested first so a lock arriving on the timeout cycle wins.
                if (w_locked_s) begin
                    w_state_nxt = S_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_cnt_nxt = '0;
`ifdef PLL_RETRY_LIMIT_EN
                    if (r_retry == RETRY_W'(MAX_RETRIES)) begin
                        w_state_nxt = S_FAULT;
                    end else
`endif
                    begin
                        w_state_nxt = S_PLL_RST;
                        if (r_retry != {RETRY_W{1'b1}}) begin
                            w_retry_nxt = r_retry + 1'b1;
                        end
                    end
                end
            end
            S_STABLE: begin
                // A dropout here is a lock glitch: wait again without resetting the PLL.
                if (!w_locked_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                    w_retry_nxt = '0;
                end
            end
            S_RUN: begin
                w_cnt_nxt = '0;
                if (!w_locked_s) begin
                    w_state_nxt = S_PLL_RST;
                end
            end
            S_FAULT: begin
                w_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt = S_PLL_RST;
                w_cnt_nxt   = '0;
            end
        endcase

        w_pll_rst_nxt      = (w_state_nxt == S_PLL_RST) || (w_state_nxt == S_FAULT);
        // Release the core one cycle after RUN entry, but drop it on the exit edge itself.
        w_core_reset_n_nxt = (r_state == S_RUN) && (w_state_nxt == S_RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_PLL_RST;
            r_cnt          <= '0;
            r_retry        <= '0;
            r_pll_rst      <= 1'b1;
            r_core_reset_n <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_retry        <= w_retry_nxt;
            r_pll_rst      <= w_pll_rst_nxt;
            r_core_reset_n <= w_core_reset_n_nxt;
        end
    end

`ifdef PLL_RETRY_LIMIT_EN
    logic r_fault;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= (w_state_nxt == S_FAULT);
        end
    end

    assign fault = r_fault;
`else
    assign fault = 1'b0;
`endif

    assign pll_rst      = r_pll_rst;
    assign core_reset_n = r_core_reset_n;
    assign retry_count  = r_retry;

endmodule
